// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state encoding and baud divisor helper for uart_rx
// Contents: OVERSAMPLE ticks per bit, ST_* state codes (state_t), calc_div() clocks-per-tick.
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_START     = 3'd1;
  localparam state_t ST_DATA      = 3'd2;
  localparam state_t ST_PARITY    = 3'd3;
  localparam state_t ST_STOP      = 3'd4;
  localparam state_t ST_WAIT_HIGH = 3'd5;
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running divider producing a one-cycle tick every DIV clocks
// Ports: clk_i clock, rst_ni async active-low reset, restart_i zeroes the count
//        so the next tick lands DIV clocks later, tick_o oversample enable.
module baud_tick_gen #(
  parameter int DIV = 27
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q;
  assign tick_o = cnt_q == W'(DIV - 1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= (restart_i || tick_o) ? '0 : cnt_q + W'(1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling UART receiver, 8 data bits LSB first, one stop bit
// Ports: CLK50M clock, n_RST async active-low reset, RxD serial line (idle high),
//        rdy_clr acknowledge pulse clearing all flags, DATA_OUT last good byte,
//        Rx_RDY byte valid, FRM_ERR stop bit low, OVR_ERR byte landed on unread byte,
//        PAR_ERR even-parity mismatch (all flags sticky until rdy_clr).
// Macro UART_RX_PARITY_EN: adds an even parity bit between data and stop; otherwise PAR_ERR=0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK50M,
  input  logic       n_RST,
  input  logic       RxD,
  input  logic       rdy_clr,
  output logic [7:0] DATA_OUT,
  output logic       Rx_RDY,
  output logic       FRM_ERR,
  output logic       OVR_ERR,
  output logic       PAR_ERR
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD);
`ifdef UART_RX_PARITY_EN
  localparam state_t ST_AFTER_DATA = ST_PARITY;
`else
  localparam state_t ST_AFTER_DATA = ST_STOP;
`endif
  // [0],[1] form the synchronizer; [2] holds the previous synchronized value for edge detection
  logic [2:0] sync_q;
  logic       rx, fall, tick, restart, sample, accept, frm_set;
  state_t     state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shift_q, shift_d, data_q;
  logic       rdy_q, frm_q, ovr_q;
  assign rx      = sync_q[1];
  assign fall    = sync_q[2] & ~sync_q[1];
  assign restart = (state_q == ST_IDLE) && fall;
  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk_i    (CLK50M),
    .rst_ni   (n_RST),
    .restart_i(restart),
    .tick_o   (tick)
  );
`ifdef UART_RX_PARITY_EN
  logic par_set, par_bad_q, par_bad_d, par_q;
`endif
  always_comb begin
    // START samples at mid-bit (8 ticks), every later bit one full bit (16 ticks) on
    sample  = tick && tcnt_q == (state_q == ST_START ? 4'd7 : 4'd15);
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    accept  = 1'b0;
    frm_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set   = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      ST_IDLE:  state_d = fall ? ST_START : ST_IDLE;
      ST_START: if (sample) state_d = rx ? ST_IDLE : ST_DATA;
      ST_DATA: if (sample) begin
        shift_d = {rx, shift_q[7:1]};
        bcnt_d  = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) state_d = ST_AFTER_DATA;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (sample) begin
        par_bad_d = ^{shift_q, rx};
        par_set   = par_bad_d;
        state_d   = ST_STOP;
      end
`endif
      ST_STOP: if (sample) begin
        accept  = rx;
        frm_set = ~rx;
        state_d = rx ? ST_IDLE : ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: state_d = rx ? ST_IDLE : ST_WAIT_HIGH;
      default:      state_d = ST_IDLE;
    endcase
    tcnt_d = state_d != state_q ? 4'd0 : tcnt_q + {3'd0, tick};
  end
  always_ff @(posedge CLK50M or negedge n_RST)
    if (!n_RST) begin
      sync_q  <= 3'b111;
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      frm_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], RxD};
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= accept ? shift_q : data_q;
      // a new byte beats a simultaneous acknowledge; the acknowledge still cancels overrun
      rdy_q   <= accept | (rdy_q & ~rdy_clr);
      frm_q   <= frm_set | (frm_q & ~rdy_clr);
      ovr_q   <= ~rdy_clr & (ovr_q | (accept & rdy_q));
    end
`ifdef UART_RX_PARITY_EN
  // par_bad_q lets acceptance re-assert PAR_ERR if it was acknowledged mid-frame
  always_ff @(posedge CLK50M or negedge n_RST)
    if (!n_RST) begin
      par_bad_q <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      par_q     <= par_set | (accept & par_bad_q) | (par_q & ~rdy_clr);
    end
  assign PAR_ERR = par_q;
`else
  assign PAR_ERR = 1'b0;
`endif
  assign DATA_OUT = data_q;
  assign Rx_RDY   = rdy_q;
  assign FRM_ERR  = frm_q;
  assign OVR_ERR  = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a byte-level flag model of uart_rx
module tb_uart_rx;
  localparam int DIV = 50000000 / (115200 * 16);
  localparam int BP  = DIV * 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int NB  = 10;
`else
  localparam bit PAR = 1'b0;
  localparam int NB  = 9;
`endif
  logic clk = 1'b0, n_rst = 1'b0, rxd = 1'b1, rdy_clr = 1'b0;
  logic [7:0] data_out;
  logic rx_rdy, frm_err, ovr_err, par_err;
  int total = 0, bad = 0, cyc = 0, rise_at = -1;
  bit seen = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit m_rdy = 1'b0, m_frm = 1'b0, m_ovr = 1'b0, m_par = 1'b0;

  uart_rx dut (
    .CLK50M  (clk),
    .n_RST   (n_rst),
    .RxD     (rxd),
    .rdy_clr (rdy_clr),
    .DATA_OUT(data_out),
    .Rx_RDY  (rx_rdy),
    .FRM_ERR (frm_err),
    .OVR_ERR (ovr_err),
    .PAR_ERR (par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"}, data_out, m_data);
    chk({tag, ".rdy"}, rx_rdy, m_rdy);
    chk({tag, ".frm"}, frm_err, m_frm);
    chk({tag, ".ovr"}, ovr_err, m_ovr);
    chk({tag, ".par"}, par_err, m_par);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // hold the line for n clocks, noting the first rise of Rx_RDY; a rise ends any held acknowledge
  task automatic line(input logic v, input int n);
    rxd = v;
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (!seen && rx_rdy) begin
        seen    = 1'b1;
        rise_at = cyc;
        rdy_clr = 1'b0;
      end
    end
  endtask

  task automatic clr();
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
    {m_rdy, m_frm, m_ovr, m_par} = '0;
  endtask

  // one frame; hold keeps rdy_clr high through the stop bit so it coincides with acceptance
  task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_ok, input bit hold);
    cyc     = 0;
    seen    = rx_rdy;
    rise_at = -1;
    line(1'b0, BP);
    for (int i = 0; i < 8; i++) line(b[i], BP);
    if (PAR) line(par_ok ? ^b : ~^b, BP);
    if (hold) begin
      rdy_clr = 1'b1;
      seen    = 1'b0;
    end
    line(stop_ok, BP);
    rdy_clr = 1'b0;
    rxd     = 1'b1;
    if (hold) {m_rdy, m_frm, m_ovr, m_par} = '0;
    m_par = m_par | (PAR & !par_ok);
    if (stop_ok) begin
      m_ovr  = m_ovr | m_rdy;
      m_rdy  = 1'b1;
      m_data = b;
    end else m_frm = 1'b1;
  endtask

  initial begin
    idle(5);
    check_all("reset");
    n_rst = 1'b1;
    idle(10);
    send(8'h01, 1'b1, 1'b1, 1'b0);
    idle(20);
    chk("rise_seen", seen, 1'b1);
    chk("rise_window", rise_at >= NB * BP && rise_at < (NB + 1) * BP, 1'b1);
    check_all("byte01");
    clr();
    rxd = 1'b0;
    idle(100);
    rxd = 1'b1;
    idle(BP);
    check_all("glitch");
    send(8'hA5, 1'b1, 1'b1, 1'b0);
    idle(20);
    check_all("byteA5");
    clr();
    send(8'h3C, 1'b0, 1'b1, 1'b0);
    idle(20);
    check_all("frame_err");
    clr();
    send(8'h55, 1'b1, 1'b1, 1'b0);
    idle(20);
    check_all("byte55");
    clr();
    send(8'h11, 1'b1, 1'b1, 1'b0);
    idle(20);
    send(8'h22, 1'b1, 1'b1, 1'b0);
    idle(20);
    check_all("overrun");
    clr();
    check_all("overrun_clr");
    send(8'h9A, 1'b1, 1'b1, 1'b0);
    idle(20);
    send(8'hC3, 1'b1, 1'b1, 1'b1);
    idle(20);
    check_all("set_wins");
    // 0xF8: bits 3..7, parity and stop are all high, so nothing after bit 3 forms a falling edge
    rxd = 1'b0;
    idle(4 * BP);
    rxd = 1'b1;
    idle(BP / 2);
    n_rst = 1'b0;
    #1;
    m_data = 8'h00;
    {m_rdy, m_frm, m_ovr, m_par} = '0;
    check_all("reset_async");
    idle(4);
    n_rst = 1'b1;
    idle(BP / 2 + 4 * BP + (NB - 8) * BP + 20);
    check_all("reset_abandon");
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, 1'b0);
    idle(20);
    check_all("parity_err");
    clr();
`endif
    for (int k = 0; k < 5; k++) begin
      logic [7:0] b;
      bit so, po, ho;
      b  = 8'($urandom);
      so = $urandom_range(0, 4) != 0;
      po = $urandom_range(0, 3) != 0;
      ho = so && $urandom_range(0, 3) == 0;
      send(b, so, po, ho);
      idle(20);
      check_all($sformatf("rand%0d", k));
      if ($urandom_range(0, 1) == 1) begin
        clr();
        check_all($sformatf("rand%0d_clr", k));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLK_FREQ, 50000000, input clock frequency in Hz.
REQ-002 Parameter: BAUD, 115200, line bit rate; oversample divisor DIV = CLK_FREQ/(BAUD*16), integer-truncated (27 at defaults).
REQ-003 Port: CLK50M  input  1  single system clock; all state on rising edge.
REQ-004 Port: n_RST  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: RxD  input  1  asynchronous serial line, idle high.
REQ-006 Port: rdy_clr  input  1  one-cycle pulse that acknowledges the byte and clears the flags.
REQ-007 Port: DATA_OUT  output  8  last received byte.
REQ-008 Port: Rx_RDY  output  1  byte valid, sticky until rdy_clr.
REQ-009 Port: FRM_ERR  output  1  stop bit sampled low, sticky until rdy_clr.
REQ-010 Port: OVR_ERR  output  1  byte completed while Rx_RDY was still set, sticky until rdy_clr.
REQ-011 Port: PAR_ERR  output  1  parity mismatch, sticky until rdy_clr; constant 0 when parity is compiled out.

Function
REQ-012 RxD SHALL pass through a 2-flop synchronizer before any use; added latency of 2 cycles is accepted.
REQ-013 A tick SHALL fire once every DIV clocks, free-running; the counter is restarted on each IDLE-to-START transition so the sampling phase is aligned to the start edge.
REQ-014 FSM states: IDLE, START, DATA, PARITY (present only with parity), STOP, WAIT_HIGH.
REQ-015 IDLE: a synchronized high-to-low transition SHALL move to START.
REQ-016 START: after 8 ticks, sample the line; if low go to DATA, else treat as a glitch and return to IDLE with no flag change.
REQ-017 DATA: sample every 16 ticks, 8 bits, LSB first, into a shift register; after bit 7 go to PARITY or STOP.
REQ-018 PARITY: sample after 16 ticks; even parity over the 8 data bits plus the parity bit; on mismatch set PAR_ERR.
REQ-019 STOP: sample after 16 ticks; if high, load DATA_OUT and set Rx_RDY in the same cycle, then go to IDLE.
REQ-020 STOP sampled low: set FRM_ERR, leave DATA_OUT and Rx_RDY unchanged, go to WAIT_HIGH.
REQ-021 WAIT_HIGH: remain until the synchronized line is high, then go to IDLE.
REQ-022 If Rx_RDY=1 when a new byte is accepted, set OVR_ERR and overwrite DATA_OUT with the new byte.
REQ-023 rdy_clr SHALL clear Rx_RDY, FRM_ERR, OVR_ERR and PAR_ERR on the next edge; it SHALL NOT affect the FSM.
REQ-024 If rdy_clr and byte acceptance occur in the same cycle, the set wins: Rx_RDY=1, OVR_ERR not set, and the other flags are cleared then re-evaluated for the new byte.
REQ-025 A byte with a parity error is still delivered (Rx_RDY=1, PAR_ERR=1) provided its stop bit is valid.

Reset
REQ-026 While n_RST=0: state=IDLE, counters=0, synchronizer=1, DATA_OUT=8'h00, Rx_RDY=FRM_ERR=OVR_ERR=PAR_ERR=0.
REQ-027 Reset mid-frame SHALL abandon the frame; after release, the remaining bits of that frame SHALL NOT raise Rx_RDY unless a new falling edge is detected.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state included, frame = start + 8 data + even parity + stop.
REQ-029 Macro undefined: no PARITY state, frame = start + 8 data + stop, PAR_ERR tied 0.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state enumeration, the constant OVERSAMPLE=16, and the DIV computation function.
REQ-031 Sub-module baud_tick_gen: parameterized divider with a restart input, producing the tick enable.

Verification
REQ-032 Defaults, parity off; send 0x01 (bit period 432 clocks) -> Rx_RDY rises about 9.5 bit periods after the start edge, DATA_OUT=0x01, all error flags 0.
REQ-033 Low pulse on RxD lasting 100 clocks -> no Rx_RDY; FSM back in IDLE; next byte 0xA5 received correctly.
REQ-034 Send 0x3C with stop bit forced 0 -> FRM_ERR=1, Rx_RDY=0, DATA_OUT unchanged; next byte 0x55 received after the line returns high.
REQ-035 Send 0x11 then 0x22 with no rdy_clr -> OVR_ERR=1, DATA_OUT=0x22; a single rdy_clr pulse clears Rx_RDY and OVR_ERR.
REQ-036 Assert n_RST mid-frame at data bit 3 -> outputs go to reset values immediately; after release, no Rx_RDY for the remainder of that frame.
REQ-037 UART_RX_PARITY_EN defined; send 0x07 with parity bit 0 (correct value 1) -> Rx_RDY=1, PAR_ERR=1, DATA_OUT=0x07.
